inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ICACHE_ENTRIES, default 16, number of direct-mapped icache lines (one 32-bit word each, power of two).
REQ-002 Port clk_in, input, 1, single clock; all state updates on posedge.
REQ-003 Port rst_in, input, 1, synchronous, active-high reset (`RstEnable).
REQ-004 Port rdy_in, input, 1, global enable; low freezes all state and outputs.
REQ-005 Port stall_in, input, 1, decode not ready; the held instruction is not consumed.
REQ-006 Port branch_flag_in, input, 1, redirect request from execute.
REQ-007 Port branch_target_in, input, 32 (`InstAddrBus), redirect PC.
REQ-008 Port if_req_out, output, 1, instruction read request to mem_ctrl.
REQ-009 Port inst_addr_out, output, 32, word address of the outstanding request.
REQ-010 Port inst_done_in, input, 1, one-cycle completion pulse from mem_ctrl.
REQ-011 Port inst_in, input, 32 (`RegBus), fetched word, valid with inst_done_in.
REQ-012 Port mem_busy_in, input, 2, mem_ctrl busy; bit[0] = data access in progress.
REQ-013 Port if_valid_out, output, 1, instruction presented to decode.
REQ-014 Port if_pc_out, output, 32, PC of the presented instruction.
REQ-015 Port if_inst_out, output, 32, presented instruction word.

Function
REQ-016 Internal state: pc (next PC to fetch), fetch_addr, state in {IDLE, FETCH}, discard flag.
REQ-017 Icache: index = pc[log2(ICACHE_ENTRIES)+1:2], tag = remaining upper PC bits, one valid bit per line.
REQ-018 Transfer: the instruction is consumed on a cycle with if_valid_out=1 and stall_in=0; while stall_in=1, if_valid_out, if_pc_out and if_inst_out hold.
REQ-019 IDLE hit, output free or being consumed: next cycle if_valid_out=1, if_pc_out=pc, if_inst_out=cached word, pc<=pc+4 (1-cycle latency, 32-bit wrap).
REQ-020 IDLE miss with mem_busy_in[0]=0: if_req_out<=1, inst_addr_out<=pc, fetch_addr<=pc, state<=FETCH.
REQ-021 IDLE miss with mem_busy_in[0]=1: no request is raised; remain IDLE.
REQ-022 FETCH: if_req_out stays 1 and inst_addr_out stays stable until inst_done_in is sampled.
REQ-023 At the posedge sampling inst_done_in=1: if_req_out<=0 in the same edge; line[fetch_addr] is written (valid, tag, inst_in); state<=IDLE.
REQ-024 On that same edge, with discard=0 and the output free: present inst_in with if_pc_out=fetch_addr and set pc<=fetch_addr+4; otherwise present nothing and leave pc unchanged, so the next IDLE cycle hits.
REQ-025 branch_flag_in=1 (priority over all else except reset/rdy_in): if_valid_out<=0, pc<=branch_target_in.
REQ-026 Branch in FETCH: the request is not dropped; discard<=1, and the returning word fills the cache but is not presented; discard clears on inst_done_in.
REQ-027 Branch and inst_done_in on the same edge: cache fill occurs, output flushed, pc<=branch_target_in.
REQ-028 A new request is never raised on the edge after inst_done_in (minimum one idle cycle between requests).
REQ-029 rdy_in=0: no register changes; if_req_out holds its value.

Reset
REQ-030 On rst_in=1 at posedge: if_req_out=0, inst_addr_out=0, if_valid_out=0, if_pc_out=0, if_inst_out=0, pc=0, state=IDLE, discard=0, all icache valid bits=0.
REQ-031 Reset mid-FETCH abandons the request (if_req_out=0 next edge); mem_ctrl is reset by the same rst_in.

Structure
REQ-032 Shared defines.v holds `InstAddrBus, `RegBus, `RstEnable, `True_v/`False_v, `ZeroWord and the icache index/tag width macros.
REQ-033 Sub-module icache (storage, valid bits, hit compare, write port); FSM and PC logic stay in inst_fetch.

Verification
REQ-034 Reset, then cold miss at PC 0: if_req_out=1, inst_addr_out=0x0; inst_done_in pulse with inst_in=0x00000013 -> next edge if_valid_out=1, if_pc_out=0x0, if_inst_out=0x00000013, if_req_out=0.
REQ-035 Loop re-entry to PC 0x0 after fill: no if_req_out; if_valid_out=1 one cycle later with 0x00000013.
REQ-036 Miss while mem_busy_in=2'b01 for 5 cycles: if_req_out stays 0, then rises on the first cycle with mem_busy_in[0]=0.
REQ-037 Branch to 0x100 during FETCH of 0x8: request held to inst_done_in; word for 0x8 not presented but cached; next request inst_addr_out=0x100.
REQ-038 stall_in=1 for 3 cycles with if_valid_out=1, PC 0x4: outputs stable; pc advances exactly once after release.
REQ-039 rdy_in=0 mid-FETCH for 4 cycles: all outputs frozen; completes normally after rdy_in=1.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam int          REG_W       = 32;
  localparam logic        RST_ENABLE  = 1'b1;
  localparam logic        TRUE_V      = 1'b1;
  localparam logic        FALSE_V     = 1'b0;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  // Fetch controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  // Icache index width for a given line count (one word per line).
  function automatic int icache_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Icache tag width: word address bits left above the index.
  function automatic int icache_tag_w(input int entries);
    return INST_ADDR_W - 2 - $clog2(entries);
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Addresses arrive as word addresses (byte address bits [31:2]).
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [29:0] rd_addr_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o,
  input  logic        wr_en_i,
  input  logic [29:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int IDX_W = icache_idx_w(ENTRIES);
  localparam int TAG_W = icache_tag_w(ENTRIES);

  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      data_q  [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign rd_idx = rd_addr_i[IDX_W-1:0];
  assign rd_tag = rd_addr_i[29:IDX_W];
  assign wr_idx = wr_addr_i[IDX_W-1:0];
  assign wr_tag = wr_addr_i[29:IDX_W];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= TRUE_V;
    end
  end

  // Tag and data storage: no reset needed, guarded by the valid bits.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC sequencing, icache lookup, miss handling towards
// mem_ctrl and a one-entry output register towards decode.
//
// Decode handshake: an instruction is handed over on any cycle where
// rdy_in=1, if_valid_out=1 and stall_in=0; while stall_in=1 the
// presented pc/instruction are held unchanged.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_ENTRIES = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         stall_in,
  input  logic         branch_flag_in,
  input  logic [31:0]  branch_target_in,
  output logic         if_req_out,
  output logic [31:0]  inst_addr_out,
  input  logic         inst_done_in,
  input  logic [31:0]  inst_in,
  input  logic [1:0]   mem_busy_in,
  output logic         if_valid_out,
  output logic [31:0]  if_pc_out,
  output logic [31:0]  if_inst_out,
  output fetch_state_e dbg_state_out
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_addr_q;
  logic         discard_q;
  logic         cool_q;       // one idle cycle enforced after each completion
  logic         req_q;
  logic [31:0]  addr_q;
  logic         valid_q;
  logic [31:0]  out_pc_q;
  logic [31:0]  out_inst_q;

  logic         cache_hit;
  logic [31:0]  cache_data;
  logic         fill_en;
  logic         out_free;
  logic         consume;
  logic [31:0]  pc_next_d;
  logic [31:0]  fetch_next_d;
  logic         unused_busy;

  assign unused_busy  = mem_busy_in[1];
  assign consume      = valid_q && !stall_in;
  assign out_free     = !valid_q || !stall_in;
  assign pc_next_d    = pc_q + 32'd4;
  assign fetch_next_d = fetch_addr_q + 32'd4;
  // A returning word always fills the cache, even when it is discarded.
  assign fill_en      = (rst_in != RST_ENABLE) && rdy_in &&
                        (state_q == ST_FETCH) && inst_done_in;

  inst_fetch_icache #(
    .ENTRIES (ICACHE_ENTRIES)
  ) u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_addr_i (pc_q[31:2]),
    .hit_o     (cache_hit),
    .rd_data_o (cache_data),
    .wr_en_i   (fill_en),
    .wr_addr_i (fetch_addr_q[31:2]),
    .wr_data_i (inst_in)
  );

  // Fetch FSM with registered request and decode-side outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      state_q      <= ST_IDLE;
      pc_q         <= ZERO_WORD;
      fetch_addr_q <= ZERO_WORD;
      discard_q    <= FALSE_V;
      cool_q       <= FALSE_V;
      req_q        <= FALSE_V;
      addr_q       <= ZERO_WORD;
      valid_q      <= FALSE_V;
      out_pc_q     <= ZERO_WORD;
      out_inst_q   <= ZERO_WORD;
    end else if (rdy_in) begin
      if (consume) begin
        valid_q <= FALSE_V;
      end
      if (branch_flag_in) begin
        // Redirect: flush the output; an outstanding request is kept alive
        // and its word only refills the cache.
        valid_q <= FALSE_V;
        pc_q    <= branch_target_in;
        if (state_q == ST_FETCH) begin
          if (inst_done_in) begin
            req_q     <= FALSE_V;
            state_q   <= ST_IDLE;
            discard_q <= FALSE_V;
            cool_q    <= TRUE_V;
          end else begin
            discard_q <= TRUE_V;
          end
        end else begin
          cool_q <= FALSE_V;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            cool_q <= FALSE_V;
            if (cache_hit) begin
              if (out_free) begin
                valid_q    <= TRUE_V;
                out_pc_q   <= pc_q;
                out_inst_q <= cache_data;
                pc_q       <= pc_next_d;
              end
            end else if (!mem_busy_in[0] && !cool_q) begin
              req_q        <= TRUE_V;
              addr_q       <= pc_q;
              fetch_addr_q <= pc_q;
              state_q      <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (inst_done_in) begin
              req_q     <= FALSE_V;
              state_q   <= ST_IDLE;
              discard_q <= FALSE_V;
              cool_q    <= TRUE_V;
              if (!discard_q && out_free) begin
                valid_q    <= TRUE_V;
                out_pc_q   <= fetch_addr_q;
                out_inst_q <= inst_in;
                pc_q       <= fetch_next_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign if_req_out    = req_q;
  assign inst_addr_out = addr_q;
  assign if_valid_out  = valid_q;
  assign if_pc_out     = out_pc_q;
  assign if_inst_out   = out_inst_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed multi-cycle sequences followed by a table
// of redirect/run records, with every handed-over instruction checked
// against a queue of expected {pc, inst} pairs.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_in, rdy_in, stall_in, branch_flag_in;
  logic [31:0]  branch_target_in;
  logic         if_req_out;
  logic [31:0]  inst_addr_out;
  logic         inst_done_in;
  logic [31:0]  inst_in;
  logic [1:0]   mem_busy_in;
  logic         if_valid_out;
  logic [31:0]  if_pc_out, if_inst_out;
  fetch_state_e dbg_state_out;

  always #5 clk = ~clk;

  inst_fetch #(.ICACHE_ENTRIES(16)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stall_in         (stall_in),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .if_req_out       (if_req_out),
    .inst_addr_out    (inst_addr_out),
    .inst_done_in     (inst_done_in),
    .inst_in          (inst_in),
    .mem_busy_in      (mem_busy_in),
    .if_valid_out     (if_valid_out),
    .if_pc_out        (if_pc_out),
    .if_inst_out      (if_inst_out),
    .dbg_state_out    (dbg_state_out)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];   // {pc, inst}

  bit mem_auto = 1'b0;
  int mem_lat  = 1;
  int lat_cnt  = 0;

  typedef struct {
    logic [31:0] target;
    int          count;
    int          lat;
    int          stall_pct;
  } row_t;
  row_t rows[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 + (a << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // One clock: score any hand-over at this edge, advance, then run the
  // memory responder on the freshly updated outputs.
  task automatic tick();
    logic [63:0] e;
    if (rdy_in && if_valid_out && !stall_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer_pc", if_pc_out, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", if_pc_out, e[63:32]);
        check("xfer_inst", if_inst_out, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (inst_done_in) begin
        if (rdy_in) inst_done_in = 1'b0;
      end else if (if_req_out && rdy_in) begin
        if (lat_cnt >= mem_lat) begin
          inst_done_in = 1'b1;
          inst_in      = mem_word(inst_addr_out);
          lat_cnt      = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rows[0] = '{32'h0000_0040, 4, 1, 0};
    rows[1] = '{32'h0000_0000, 4, 2, 30};
    rows[2] = '{32'h0000_0000, 4, 1, 50};
    rows[3] = '{32'hFFFF_FFF8, 4, 1, 20};
    rows[4] = '{32'h0000_0100, 3, 3, 0};
    rows[5] = '{32'h0000_0008, 2, 0, 40};

    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; branch_flag_in = 1'b0;
    branch_target_in = '0; inst_done_in = 1'b0; inst_in = '0; mem_busy_in = 2'b00;

    // Reset values
    tick(); tick();
    check("rst_req", {31'd0, if_req_out}, 32'd0);
    check("rst_addr", inst_addr_out, 32'd0);
    check("rst_valid", {31'd0, if_valid_out}, 32'd0);
    check("rst_pc", if_pc_out, 32'd0);
    check("rst_inst", if_inst_out, 32'd0);
    check("rst_state", {31'd0, dbg_state_out}, {31'd0, ST_IDLE});
    rst_in = 1'b0;

    // Cold miss at PC 0
    tick();
    check("cold_req", {31'd0, if_req_out}, 32'd1);
    check("cold_addr", inst_addr_out, 32'd0);
    tick();
    check("cold_req_held", {31'd0, if_req_out}, 32'd1);
    check("cold_addr_held", inst_addr_out, 32'd0);
    inst_done_in = 1'b1; inst_in = 32'h0000_0013; stall_in = 1'b1;
    push_exp(32'h0);
    tick();
    check("cold_valid", {31'd0, if_valid_out}, 32'd1);
    check("cold_pc", if_pc_out, 32'h0);
    check("cold_inst", if_inst_out, 32'h0000_0013);
    check("cold_req_drop", {31'd0, if_req_out}, 32'd0);
    inst_done_in = 1'b0; stall_in = 1'b0;
    tick();
    check("gap_req", {31'd0, if_req_out}, 32'd0);
    tick();
    check("pc4_req", {31'd0, if_req_out}, 32'd1);
    check("pc4_addr", inst_addr_out, 32'h4);
    inst_done_in = 1'b1; inst_in = mem_word(32'h4);
    push_exp(32'h4);
    tick();
    check("pc4_valid", {31'd0, if_valid_out}, 32'd1);
    check("pc4_pc", if_pc_out, 32'h4);
    inst_done_in = 1'b0;

    // Loop re-entry to 0 hits the cache
    branch_flag_in = 1'b1; branch_target_in = 32'h0;
    tick();
    check("loop_flush_valid", {31'd0, if_valid_out}, 32'd0);
    check("loop_flush_req", {31'd0, if_req_out}, 32'd0);
    branch_flag_in = 1'b0;
    push_exp(32'h0);
    tick();
    check("loop_req", {31'd0, if_req_out}, 32'd0);
    check("loop_valid", {31'd0, if_valid_out}, 32'd1);
    check("loop_pc", if_pc_out, 32'h0);
    check("loop_inst", if_inst_out, 32'h0000_0013);

    // Miss at 0x8 while mem_ctrl busy
    mem_busy_in = 2'b01;
    push_exp(32'h4);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_no_req", {31'd0, if_req_out}, 32'd0);
    end
    mem_busy_in = 2'b00;
    tick();
    check("busy_release_req", {31'd0, if_req_out}, 32'd1);
    check("busy_release_addr", inst_addr_out, 32'h8);

    // Branch to 0x100 during fetch of 0x8
    branch_flag_in = 1'b1; branch_target_in = 32'h100;
    tick();
    branch_flag_in = 1'b0;
    check("br_req_held", {31'd0, if_req_out}, 32'd1);
    check("br_addr_held", inst_addr_out, 32'h8);
    tick();
    check("br_req_held2", {31'd0, if_req_out}, 32'd1);
    inst_done_in = 1'b1; inst_in = mem_word(32'h8);
    tick();
    inst_done_in = 1'b0;
    check("br_done_req", {31'd0, if_req_out}, 32'd0);
    check("br_discard_valid", {31'd0, if_valid_out}, 32'd0);
    tick();
    check("br_gap_req", {31'd0, if_req_out}, 32'd0);
    tick();
    check("br_new_req", {31'd0, if_req_out}, 32'd1);
    check("br_new_addr", inst_addr_out, 32'h100);
    inst_done_in = 1'b1; inst_in = mem_word(32'h100); stall_in = 1'b1;
    tick();
    inst_done_in = 1'b0;
    check("t100_valid", {31'd0, if_valid_out}, 32'd1);
    check("t100_pc", if_pc_out, 32'h100);
    check("t100_inst", if_inst_out, mem_word(32'h100));
    // 0x8 must now be served from the cache
    branch_flag_in = 1'b1; branch_target_in = 32'h8;
    tick();
    branch_flag_in = 1'b0;
    tick();
    check("disc_hit_req", {31'd0, if_req_out}, 32'd0);
    check("disc_hit_valid", {31'd0, if_valid_out}, 32'd1);
    check("disc_hit_pc", if_pc_out, 32'h8);
    check("disc_hit_inst", if_inst_out, mem_word(32'h8));

    // Stall with PC 0x4 presented
    branch_flag_in = 1'b1; branch_target_in = 32'h4;
    tick();
    branch_flag_in = 1'b0;
    tick();
    check("stall_pc0", if_pc_out, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, if_valid_out}, 32'd1);
      check("stall_pc", if_pc_out, 32'h4);
      check("stall_inst", if_inst_out, mem_word(32'h4));
    end
    stall_in = 1'b0;
    push_exp(32'h4); push_exp(32'h8);
    tick();
    stall_in = 1'b1;
    check("release_pc", if_pc_out, 32'h8);
    check("release_valid", {31'd0, if_valid_out}, 32'd1);
    tick();
    check("release_next_req", {31'd0, if_req_out}, 32'd1);
    check("release_next_addr", inst_addr_out, 32'hC);

    // rdy_in low mid-fetch
    rdy_in = 1'b0; stall_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_req", {31'd0, if_req_out}, 32'd1);
      check("frz_addr", inst_addr_out, 32'hC);
      check("frz_valid", {31'd0, if_valid_out}, 32'd1);
      check("frz_pc", if_pc_out, 32'h8);
      check("frz_inst", if_inst_out, mem_word(32'h8));
    end
    rdy_in = 1'b1; mem_lat = 1; lat_cnt = 0; mem_auto = 1'b1;
    push_exp(32'hC);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) tick();
    check("frz_resume_left", exp_q.size(), 32'd0);
    exp_q.delete();

    // Table of redirect/run records
    foreach (rows[r]) begin
      stall_in = 1'b1; mem_busy_in = 2'b00;
      branch_flag_in = 1'b1; branch_target_in = rows[r].target;
      mem_lat = rows[r].lat;
      tick();
      branch_flag_in = 1'b0;
      for (int i = 0; i < rows[r].count; i++) push_exp(rows[r].target + 32'(4 * i));
      for (int c = 0; c < 600 && exp_q.size() > 0; c++) begin
        stall_in    = ($urandom_range(99) < rows[r].stall_pct);
        mem_busy_in = {1'b0, ($urandom_range(3) == 0)};
        tick();
      end
      check("row_left", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    stall_in = 1'b1; mem_busy_in = 2'b00;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
